// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: bundles the producer write port, the UART strobe/busy
// pair and the FIFO status/debug outputs of uart_tx_fifo.
//
// Handshake semantics:
//   - Write side: i_wr_data is enqueued on every rising edge where i_wr_en is
//     high and o_full is low. A write while full is dropped and sets o_overflow.
//   - UART side: o_tx_stb is a one-cycle pulse. o_tx_data is valid in that
//     cycle and holds its value afterwards. A new strobe is only issued while
//     i_tx_busy is low. After each strobe the block waits for i_tx_busy to rise
//     and then fall, or gives up if busy does not rise within ACK_TIMEOUT cycles.
interface uart_tx_fifo_if #(
    parameter int DATA_W     = 4,
    parameter int DEPTH_LOG2 = 4
);
    logic [DATA_W-1:0]   i_wr_data;
    logic                i_wr_en;
    logic                o_full;
    logic                o_empty;
    logic [DEPTH_LOG2:0] o_count;
    logic                o_overflow;
    logic [DATA_W-1:0]   o_tx_data;
    logic                o_tx_stb;
    logic                i_tx_busy;
    logic                o_idle;
    logic [1:0]          o_state;   // debug: FSM state (0 IDLE, 1 WAIT_HI, 2 WAIT_LO)

    modport master (
        output i_wr_data, i_wr_en, i_tx_busy,
        input  o_full, o_empty, o_count, o_overflow, o_tx_data, o_tx_stb,
               o_idle, o_state
    );

    modport slave (
        input  i_wr_data, i_wr_en, i_tx_busy,
        output o_full, o_empty, o_count, o_overflow, o_tx_data, o_tx_stb,
               o_idle, o_state
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular FIFO feeding uart_top. It issues one-cycle strobes
// paced by the UART busy flag, with a timeout if busy never rises.
// Optional feature macro: UART_TX_FIFO_FLUSH_EN adds an i_flush input.
// The flush empties the FIFO and leaves the handshake state alone.
module uart_tx_fifo #(
    parameter int DATA_W      = 4,
    parameter int DEPTH_LOG2  = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input  logic clk,
    input  logic rst,
`ifdef UART_TX_FIFO_FLUSH_EN
    input  logic i_flush,
`endif
    uart_tx_fifo_if.slave bus
);
    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int TIMER_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [TIMER_W-1:0]    timer, timer_next;
    logic [DATA_W-1:0]     tx_data;
    logic                  tx_stb, tx_stb_next;
    logic                  overflow;
    logic                  pop;
    logic                  full;
    logic                  wr_accept;
    logic                  flush;

`ifdef UART_TX_FIFO_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    // Full is judged on the registered count, so a pop in the same cycle
    // never lets a write at full through.
    assign full      = (count == (DEPTH_LOG2+1)'(DEPTH));
    assign wr_accept = bus.i_wr_en && !full && !flush;

    // Next-state and strobe decode for the UART handshake
    always_comb begin
        state_next  = state;
        timer_next  = timer;
        tx_stb_next = 1'b0;
        pop         = 1'b0;
        case (state)
            IDLE: begin
                if ((count != '0) && !bus.i_tx_busy) begin
                    pop         = 1'b1;
                    tx_stb_next = 1'b1;
                    timer_next  = '0;
                    state_next  = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.i_tx_busy) begin
                    state_next = WAIT_LO;
                end else if (timer == TIMER_W'(ACK_TIMEOUT - 1)) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!bus.i_tx_busy) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM state, handshake timer and strobe register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            timer  <= '0;
            tx_stb <= 1'b0;
        end else begin
            state  <= state_next;
            timer  <= timer_next;
            tx_stb <= tx_stb_next;
        end
    end

    // Output data holds the last issued entry
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data <= '0;
        end else if (pop) begin
            tx_data <= mem[rd_ptr];
        end
    end

    // Pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (bus.i_wr_en && full) begin
                overflow <= 1'b1;
            end
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are not reset
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= bus.i_wr_data;
        end
    end

    assign bus.o_full     = full;
    assign bus.o_empty    = (count == '0);
    assign bus.o_count    = count;
    assign bus.o_overflow = overflow;
    assign bus.o_tx_data  = tx_data;
    assign bus.o_tx_stb   = tx_stb;
    assign bus.o_idle     = (state == IDLE) && (count == '0);
    assign bus.o_state    = state;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a UART busy model,
// an expected-data queue and a strobe monitor.
module tb_uart_tx_fifo;
    localparam int DATA_W      = 4;
    localparam int DEPTH_LOG2  = 4;
    localparam int ACK_TIMEOUT = 4;
    localparam int BUSY_LEN    = 20;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_fifo_if #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) bus ();

`ifdef UART_TX_FIFO_FLUSH_EN
    logic flush = 1'b0;
`endif

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2),
        .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
`ifdef UART_TX_FIFO_FLUSH_EN
        .i_flush(flush),
`endif
        .bus    (bus)
    );

    // ---------------- bench state ----------------
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];
    int                cyc = 0;
    int                last_stb_cyc = -1;
    int                min_gap = 0;
    int                exact_gap = 0;
    int                n_stb = 0;
    bit                prev_stb = 1'b0;
    int                busy_mode = 0;   // 0: tied low, 1: UART model, 2: forced high
    int                busy_cnt = 0;
    bit                busy_pend = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- UART busy model ----------------
    // Busy rises one cycle after a strobe and stays high for BUSY_LEN cycles.
    always @(posedge clk) begin
        #1;
        if (busy_mode == 1) begin
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) bus.i_tx_busy = 1'b0;
            end else if (busy_pend) begin
                busy_pend     = 1'b0;
                bus.i_tx_busy = 1'b1;
                busy_cnt      = BUSY_LEN;
            end
            if (bus.o_tx_stb) busy_pend = 1'b1;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [DATA_W-1:0] exp_d;
        if (bus.o_tx_stb) begin
            n_stb++;
            check("stb_pulse_width", int'(prev_stb), 0);
            check("stb_while_busy", int'(bus.i_tx_busy), 0);
            if (last_stb_cyc >= 0) begin
                if (exact_gap > 0) check("stb_gap_exact", cyc - last_stb_cyc, exact_gap);
                else check("stb_gap_min", int'((cyc - last_stb_cyc) >= min_gap), 1);
            end
            last_stb_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_stb: got strobe with data %0h, required no strobe (cycle %0d)",
                         bus.o_tx_data, cyc);
            end else begin
                exp_d = exp_q.pop_front();
                check("tx_data", int'(bus.o_tx_data), int'(exp_d));
            end
        end
        prev_stb = bus.o_tx_stb;
    end

    // ---------------- driver tasks ----------------
    task automatic set_busy(input int mode, input logic level);
        busy_mode     = mode;
        busy_cnt      = 0;
        busy_pend     = 1'b0;
        bus.i_tx_busy = level;
    endtask

    // Called at a negedge; the write is sampled at the next rising edge.
    task automatic wr(input logic [DATA_W-1:0] d, input bit push);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_data = d;
        if (push) exp_q.push_back(d);
        @(negedge clk);
        bus.i_wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int i = 0;
        while (!(exp_q.size() == 0 && bus.o_idle) && i < budget) begin
            @(negedge clk);
            i++;
        end
        check(name, int'(i < budget), 1);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int s;
        rst           = 1'b1;
        bus.i_wr_en   = 1'b0;
        bus.i_wr_data = '0;
        set_busy(0, 1'b0);
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_count",    int'(bus.o_count), 0);
        check("rst_empty",    int'(bus.o_empty), 1);
        check("rst_full",     int'(bus.o_full), 0);
        check("rst_idle",     int'(bus.o_idle), 1);
        check("rst_stb",      int'(bus.o_tx_stb), 0);
        check("rst_tx_data",  int'(bus.o_tx_data), 0);
        check("rst_overflow", int'(bus.o_overflow), 0);
        rst = 1'b0;

        // Single entry
        last_stb_cyc = -1;
        min_gap = 0;
        wr(4'h2, 1'b1);
        check("t1_count_after_wr", int'(bus.o_count), 1);
        @(negedge clk);
        check("t1_stb", int'(bus.o_tx_stb), 1);
        check("t1_count_after_pop", int'(bus.o_count), 0);
        check("t1_empty", int'(bus.o_empty), 1);
        @(negedge clk);
        check("t1_stb_low", int'(bus.o_tx_stb), 0);
        wait_drain(20, "t1_drain");

        // Busy pacing
        last_stb_cyc = -1;
        min_gap = 21;
        set_busy(1, 1'b0);
        s = n_stb;
        wr(4'h1, 1'b1);
        wr(4'h2, 1'b1);
        wr(4'h3, 1'b1);
        wait_drain(200, "t2_drain");
        check("t2_strobes", n_stb - s, 3);

        // Full and overflow
        last_stb_cyc = -1;
        set_busy(2, 1'b1);
        for (int i = 0; i < 16; i++) wr(4'(i), 1'b1);
        check("t3_full", int'(bus.o_full), 1);
        check("t3_count16", int'(bus.o_count), 16);
        check("t3_no_overflow_yet", int'(bus.o_overflow), 0);
        wr(4'h5, 1'b0);
        check("t3_overflow", int'(bus.o_overflow), 1);
        check("t3_count_after_drop", int'(bus.o_count), 16);
        s = n_stb;
        set_busy(1, 1'b0);
        wait_drain(600, "t3_drain");
        check("t3_strobes", n_stb - s, 16);
        check("t3_overflow_sticky", int'(bus.o_overflow), 1);

        // Reset in WAIT_LO with 5 entries queued
        last_stb_cyc = -1;
        wr(4'h7, 1'b1);
        wr(4'h8, 1'b0);
        wr(4'h9, 1'b0);
        wr(4'hA, 1'b0);
        wr(4'hB, 1'b0);
        wr(4'hC, 1'b0);
        check("t6_count5", int'(bus.o_count), 5);
        repeat (3) @(negedge clk);
        check("t6_in_wait_lo", int'(bus.o_state), 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_count", int'(bus.o_count), 0);
        check("t6_empty", int'(bus.o_empty), 1);
        check("t6_stb", int'(bus.o_tx_stb), 0);
        check("t6_overflow", int'(bus.o_overflow), 0);
        check("t6_tx_data", int'(bus.o_tx_data), 0);
        s = n_stb;
        repeat (40) @(negedge clk);
        check("t6_no_strobe", n_stb - s, 0);
        check("t6_idle", int'(bus.o_idle), 1);

        // Timeout with busy tied low
        last_stb_cyc = -1;
        set_busy(0, 1'b0);
        exact_gap = ACK_TIMEOUT + 1;
        s = n_stb;
        wr(4'hA, 1'b1);
        wr(4'hB, 1'b1);
        wait_drain(40, "t4_drain");
        check("t4_strobes", n_stb - s, 2);
        exact_gap = 0;

        // Wrap with writes landing on pop cycles
        last_stb_cyc = -1;
        min_gap = 21;
        set_busy(2, 1'b1);
        s = n_stb;
        for (int k = 0; k < 3; k++) wr(4'(k), 1'b1);
        set_busy(1, 1'b0);
        wr(4'(3), 1'b1);
        check("t5_count_on_pop", int'(bus.o_count), 3);
        check("t5_stb_on_pop", int'(bus.o_tx_stb), 1);
        for (int k = 4; k < 40; k++) begin
            repeat (22) @(negedge clk);
            wr(4'(k), 1'b1);
            check("t5_count_on_pop", int'(bus.o_count), 3);
            check("t5_stb_on_pop", int'(bus.o_tx_stb), 1);
        end
        wait_drain(200, "t5_drain");
        check("t5_strobes", n_stb - s, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Transmit-side buffer that sits directly upstream of uart_top and drives its i_tx_data / i_tx_stb inputs. Producer logic writes nibbles into a circular FIFO at its own rate. The block issues one-cycle strobes to the UART, pacing them with the UART's o_tx_busy so that no entry is lost or strobed while a frame is in flight. The FIFO decouples bursty producers from the slow serial line.

Parameters:
DATA_W, 4, width of each entry; matches uart_top i_tx_data.
DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries).
ACK_TIMEOUT, 4, cycles to wait for busy to rise after a strobe before giving up on the handshake.

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
i_wr_data  input  DATA_W  entry to enqueue
i_wr_en  input  1  enqueue i_wr_data this cycle
o_full  output  1  count == 2**DEPTH_LOG2
o_empty  output  1  count == 0
o_count  output  DEPTH_LOG2+1  number of stored entries
o_overflow  output  1  sticky; a write was attempted while full
o_tx_data  output  DATA_W  to uart_top i_tx_data; holds last issued entry
o_tx_stb  output  1  to uart_top i_tx_stb; one-cycle pulse per entry
i_tx_busy  input  1  from uart_top o_tx_busy
o_idle  output  1  high when state IDLE and FIFO empty

Behaviour:
- Reset (rst high at a clock edge): rd_ptr = wr_ptr = 0, count = 0, state = IDLE, timer = 0. Outputs: o_tx_stb = 0, o_tx_data = 0, o_overflow = 0, o_empty = 1, o_full = 0, o_idle = 1. Reset mid-transfer discards all stored entries and any pending handshake. FIFO memory contents are don't-care.
- Write: if i_wr_en and not full, store at mem[wr_ptr], wr_ptr += 1 (wraps modulo depth). If i_wr_en while full, drop the data and set o_overflow = 1. o_overflow stays set until rst. Full is evaluated before any same-cycle pop, so a write at full is dropped even if a pop occurs that cycle.
- Pop and count: when a pop and an accepted write happen in the same cycle, count is unchanged. Otherwise count is incremented or decremented by 1. Pointers wrap with no special case.
- State machine:
  - IDLE: if count > 0 and i_tx_busy == 0, then at this edge: o_tx_data <= mem[rd_ptr], o_tx_stb <= 1, rd_ptr += 1, count -= 1, timer <= 0, go to WAIT_HI. Otherwise o_tx_stb <= 0.
  - WAIT_HI: o_tx_stb <= 0 (strobe is exactly one cycle). If i_tx_busy, go to WAIT_LO. Else if timer == ACK_TIMEOUT-1, go to IDLE. Else timer += 1.
  - WAIT_LO: stay until i_tx_busy == 0, then go to IDLE.
- Strobe spacing: at least 2 cycles between consecutive strobes, even if busy never rises.
- i_tx_busy high while in IDLE blocks issue. This covers a transfer in progress that the block did not start.
- All outputs are registered except o_full, o_empty and o_idle, which decode registered state combinationally.

Optional Feature:
UART_TX_FIFO_FLUSH_EN
- Defined: adds input port i_flush (1 bit). When i_flush is high at an edge: wr_ptr = rd_ptr = 0, count = 0, and the same-cycle write is ignored. The handshake state and o_overflow are unaffected, so an in-flight frame completes normally.
- Not defined: the i_flush port does not exist and the FIFO empties only by transmission or rst.

Test Plan:
1. Single entry: write 4'h2, i_tx_busy = 0. Response: o_tx_stb pulses exactly one cycle with o_tx_data = 4'h2, o_count 1 -> 0, o_empty = 1.
2. Busy pacing: write 4'h1, 4'h2, 4'h3 back-to-back. Model busy rising 1 cycle after each strobe and lasting 20 cycles. Response: three strobes in order 1, 2, 3, none while busy is high, each at least 21 cycles apart.
3. Full and overflow: with busy held high, write 17 entries. Response: o_full = 1 after the 16th write, o_count = 16, o_overflow = 1 after the 17th. Then release busy: the 16 original values drain in order.
4. Timeout: busy tied 0. Write 4'hA and 4'hB. Response: second strobe exactly ACK_TIMEOUT+1 = 5 cycles after the first, data A then B.
5. Wrap and simultaneous events: with busy modelled, stream 40 entries, writing on the same cycle as a pop. Response: o_count is unchanged on those cycles and output order matches input order across pointer wrap.
6. Reset mid-operation: assert rst while in WAIT_LO with 5 entries queued. Response: next cycle o_count = 0, o_empty = 1, o_tx_stb = 0, o_overflow = 0, and no strobe after busy falls.
